// File: rtl/decode_stage_pkg.sv
// riscv_pkg: shared RV32I decode definitions (opcodes, ALU ops, immediate
// formats, control bundle) and small decode helper functions.
package riscv_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_SLL    = 4'd2,
    ALU_SLT    = 4'd3,
    ALU_SLTU   = 4'd4,
    ALU_XOR    = 4'd5,
    ALU_SRL    = 4'd6,
    ALU_SRA    = 4'd7,
    ALU_OR     = 4'd8,
    ALU_AND    = 4'd9,
    ALU_PASS_B = 4'd10
  } alu_op_t;

  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_R} imm_fmt_t;

  typedef struct packed {
    alu_op_t alu_op;
    logic    alu_src_imm;
    logic    mem_read;
    logic    mem_write;
    logic    reg_write;
    logic    branch;
    logic    jump;
    logic    illegal;
  } ctrl_t;

  // SUB is only reachable from register-register ops; immediate ops use bit 30
  // of the instruction as part of the immediate except for the shift-right form.
  function automatic alu_op_t alu_from_funct3(input logic [2:0] funct3,
                                              input logic f7_bit5,
                                              input logic allow_sub);
    case (funct3)
      3'b000:  return (allow_sub && f7_bit5) ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return f7_bit5 ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  // Sign-extended 32-bit immediate; instr[31] is always the sign bit.
  function automatic logic [31:0] imm_gen(input logic [31:0] instr, input imm_fmt_t fmt);
    case (fmt)
      IMM_I:   return {{20{instr[31]}}, instr[31:20]};
      IMM_S:   return {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   return {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   return {instr[31:12], 12'b0};
      IMM_J:   return {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: return 32'b0;
    endcase
  endfunction

endpackage

// File: rtl/decode_stage_register_file.sv
// register_file: REG_COUNT x WIDTH architectural registers, two asynchronous
// read ports and one synchronous write port. x0 always reads zero.
// Build option DECODE_BYPASS_EN: a read of the register being written in the
// same cycle returns the incoming write data instead of the stored value.
module register_file
  import riscv_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int REG_COUNT = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rs1_addr,
  input  logic [4:0]       rs2_addr,
  output logic [WIDTH-1:0] rs1_data,
  output logic [WIDTH-1:0] rs2_data,
  input  logic             wb_we,
  input  logic [4:0]       wb_rd,
  input  logic [WIDTH-1:0] wb_data
);

  logic [WIDTH-1:0] rf_data [REG_COUNT];
  logic [4:0]       port_addr [2];
  logic [WIDTH-1:0] port_data [2];

  genvar gi;

  assign rf_data[0] = '0;

  generate
    for (gi = 1; gi < REG_COUNT; gi++) begin : g_entry
      logic [WIDTH-1:0] entry_reg;
      // Each entry clears on reset and captures writeback addressed to it.
      always_ff @(posedge clk) begin
        if (rst) begin
          entry_reg <= '0;
        end else if (wb_we && (wb_rd == 5'(gi))) begin
          entry_reg <= wb_data;
        end
      end
      assign rf_data[gi] = entry_reg;
    end
  endgenerate

  assign port_addr[0] = rs1_addr;
  assign port_addr[1] = rs2_addr;

  generate
    for (gi = 0; gi < 2; gi++) begin : g_read
      logic [WIDTH-1:0] data_next;
      // Read mux: stored value, optional same-cycle forward, x0 forced to zero last.
      always_comb begin
        data_next = rf_data[port_addr[gi]];
`ifdef DECODE_BYPASS_EN
        if (wb_we && (wb_rd != 5'd0) && (wb_rd == port_addr[gi])) begin
          data_next = wb_data;
        end
`endif
        if (port_addr[gi] == 5'd0) begin
          data_next = '0;
        end
      end
      assign port_data[gi] = data_next;
    end
  endgenerate

  assign rs1_data = port_data[0];
  assign rs2_data = port_data[1];

endmodule

// File: rtl/decode_stage.sv
// decode_stage: RV32I instruction decode with a registered ID/EX boundary.
// Priority is rst > flush > stall > load. During a stall only the operand data
// is refreshed (from the held rs1/rs2) so writebacks landing mid-stall are seen.
// Build option DECODE_BYPASS_EN enables register-file write-through forwarding.
module decode_stage
  import riscv_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int REG_COUNT = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] if_pc,
  input  logic [31:0]      if_instruction,
  input  logic             if_valid,
  input  logic             stall,
  input  logic             flush,
  input  logic             wb_we,
  input  logic [4:0]       wb_rd,
  input  logic [WIDTH-1:0] wb_data,
  output logic             id_valid,
  output logic [WIDTH-1:0] id_pc,
  output logic [4:0]       id_rs1,
  output logic [4:0]       id_rs2,
  output logic [4:0]       id_rd,
  output logic [WIDTH-1:0] id_rs1_data,
  output logic [WIDTH-1:0] id_rs2_data,
  output logic [WIDTH-1:0] id_imm,
  output logic [3:0]       id_alu_op,
  output logic             id_alu_src_imm,
  output logic             id_mem_read,
  output logic             id_mem_write,
  output logic             id_reg_write,
  output logic             id_branch,
  output logic             id_jump,
  output logic             id_illegal
);

  logic [6:0]       opcode;
  logic [2:0]       funct3;
  logic [6:0]       funct7;
  ctrl_t            ctrl_next;
  ctrl_t            ctrl_reg;
  imm_fmt_t         fmt_next;
  logic [4:0]       rd_next;
  logic [4:0]       rs1_next;
  logic [4:0]       rs2_next;
  logic [WIDTH-1:0] imm_next;
  logic [4:0]       rf_rs1_addr;
  logic [4:0]       rf_rs2_addr;
  logic [WIDTH-1:0] rf_rs1_data;
  logic [WIDTH-1:0] rf_rs2_data;

  assign opcode = if_instruction[6:0];
  assign funct3 = if_instruction[14:12];
  assign funct7 = if_instruction[31:25];

  // While stalled, re-read the operands of the instruction held in ID/EX.
  assign rf_rs1_addr = stall ? id_rs1 : rs1_next;
  assign rf_rs2_addr = stall ? id_rs2 : rs2_next;

  register_file #(.WIDTH(WIDTH), .REG_COUNT(REG_COUNT)) u_register_file (
    .clk      (clk),
    .rst      (rst),
    .rs1_addr (rf_rs1_addr),
    .rs2_addr (rf_rs2_addr),
    .rs1_data (rf_rs1_data),
    .rs2_data (rf_rs2_data),
    .wb_we    (wb_we),
    .wb_rd    (wb_rd),
    .wb_data  (wb_data)
  );

  // Decode opcode into control bundle, immediate format and register indices.
  // Unused source indices are zeroed so hazard checks see no false dependency.
  always_comb begin
    ctrl_next = '0;
    fmt_next  = IMM_R;
    rd_next   = if_instruction[11:7];
    rs1_next  = if_instruction[19:15];
    rs2_next  = if_instruction[24:20];
    case (opcode)
      OPC_LUI: begin
        fmt_next              = IMM_U;
        ctrl_next.alu_op      = ALU_PASS_B;
        ctrl_next.alu_src_imm = 1'b1;
        ctrl_next.reg_write   = 1'b1;
        rs1_next              = 5'd0;
        rs2_next              = 5'd0;
      end
      OPC_AUIPC: begin
        fmt_next              = IMM_U;
        ctrl_next.alu_src_imm = 1'b1;
        ctrl_next.reg_write   = 1'b1;
        rs1_next              = 5'd0;
        rs2_next              = 5'd0;
      end
      OPC_JAL: begin
        fmt_next              = IMM_J;
        ctrl_next.alu_src_imm = 1'b1;
        ctrl_next.reg_write   = 1'b1;
        ctrl_next.jump        = 1'b1;
        rs1_next              = 5'd0;
        rs2_next              = 5'd0;
      end
      OPC_JALR: begin
        fmt_next              = IMM_I;
        ctrl_next.alu_src_imm = 1'b1;
        ctrl_next.reg_write   = 1'b1;
        ctrl_next.jump        = 1'b1;
        rs2_next              = 5'd0;
      end
      OPC_BRANCH: begin
        fmt_next         = IMM_B;
        ctrl_next.branch = 1'b1;
        rd_next          = 5'd0;
      end
      OPC_LOAD: begin
        fmt_next              = IMM_I;
        ctrl_next.alu_src_imm = 1'b1;
        ctrl_next.mem_read    = 1'b1;
        ctrl_next.reg_write   = 1'b1;
        rs2_next              = 5'd0;
      end
      OPC_STORE: begin
        fmt_next              = IMM_S;
        ctrl_next.alu_src_imm = 1'b1;
        ctrl_next.mem_write   = 1'b1;
        rd_next               = 5'd0;
      end
      OPC_OP_IMM: begin
        fmt_next              = IMM_I;
        ctrl_next.alu_op      = alu_from_funct3(funct3, funct7[5], 1'b0);
        ctrl_next.alu_src_imm = 1'b1;
        ctrl_next.reg_write   = 1'b1;
        rs2_next              = 5'd0;
        if ((funct3 == 3'b001) && (funct7 != 7'b0000000)) begin
          ctrl_next.illegal = 1'b1;
        end
        if ((funct3 == 3'b101) && (funct7 != 7'b0000000) && (funct7 != 7'b0100000)) begin
          ctrl_next.illegal = 1'b1;
        end
      end
      OPC_OP: begin
        fmt_next            = IMM_R;
        ctrl_next.alu_op    = alu_from_funct3(funct3, funct7[5], 1'b1);
        ctrl_next.reg_write = 1'b1;
        if (!((funct7 == 7'b0000000) ||
              ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101))))) begin
          ctrl_next.illegal = 1'b1;
        end
      end
      default: begin
        // Includes FENCE and SYSTEM, which this revision does not support.
        ctrl_next.illegal = 1'b1;
      end
    endcase
    if (rd_next == 5'd0) begin
      ctrl_next.reg_write = 1'b0;
    end
    if (ctrl_next.illegal) begin
      ctrl_next.reg_write = 1'b0;
      ctrl_next.mem_read  = 1'b0;
      ctrl_next.mem_write = 1'b0;
      ctrl_next.branch    = 1'b0;
      ctrl_next.jump      = 1'b0;
    end
    if (!if_valid) begin
      ctrl_next = '0;
    end
    imm_next = WIDTH'($signed(imm_gen(if_instruction, fmt_next)));
  end

  // ID/EX boundary: clear on reset or flush, refresh operands on stall, else load.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      id_valid    <= 1'b0;
      id_pc       <= '0;
      id_rs1      <= 5'd0;
      id_rs2      <= 5'd0;
      id_rd       <= 5'd0;
      id_rs1_data <= '0;
      id_rs2_data <= '0;
      id_imm      <= '0;
      ctrl_reg    <= '0;
    end else if (stall) begin
      id_rs1_data <= rf_rs1_data;
      id_rs2_data <= rf_rs2_data;
    end else begin
      id_valid    <= if_valid;
      id_pc       <= if_pc;
      id_rs1      <= rs1_next;
      id_rs2      <= rs2_next;
      id_rd       <= rd_next;
      id_rs1_data <= rf_rs1_data;
      id_rs2_data <= rf_rs2_data;
      id_imm      <= imm_next;
      ctrl_reg    <= ctrl_next;
    end
  end

  assign id_alu_op      = ctrl_reg.alu_op;
  assign id_alu_src_imm = ctrl_reg.alu_src_imm;
  assign id_mem_read    = ctrl_reg.mem_read;
  assign id_mem_write   = ctrl_reg.mem_write;
  assign id_reg_write   = ctrl_reg.reg_write;
  assign id_branch      = ctrl_reg.branch;
  assign id_jump        = ctrl_reg.jump;
  assign id_illegal     = ctrl_reg.illegal;

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Instruction decode stage for the RV32I pipeline, directly downstream of fetch.
- Consumes the fetched PC and instruction word, reads the register file and decodes control fields.
- Produces sign-extended immediates and registers everything into the ID/EX boundary in one cycle.
- Honours stall from the hazard unit and flush on a taken branch.

Parameters:
- WIDTH, 32, datapath and PC width.
- REG_COUNT, 32, architectural registers; x0 hardwired to zero.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- if_pc  input  WIDTH  PC of the incoming instruction
- if_instruction  input  32  instruction word
- if_valid  input  1  incoming instruction valid
- stall  input  1  hold ID/EX outputs
- flush  input  1  taken branch; kill the instruction being decoded
- wb_we  input  1  writeback enable
- wb_rd  input  5  writeback destination
- wb_data  input  WIDTH  writeback value
- id_valid, id_pc, id_rs1, id_rs2, id_rd  output  1/WIDTH/5/5/5  registered instruction identity
- id_rs1_data, id_rs2_data, id_imm  output  WIDTH  operands and immediate
- id_alu_op  output  4  alu_op_t
- id_alu_src_imm, id_mem_read, id_mem_write, id_reg_write, id_branch, id_jump, id_illegal  output  1 each  control

Behaviour:
- Latency: 1 cycle; all outputs are registered and change on the posedge of clk.
- Reset (rst=1): every output is 0; all register-file entries are 0. Reset overrides stall, flush and writeback.
- Priority: rst > flush > stall > normal load.
- flush=1: id_valid<=0; all control outputs <=0; data outputs don't-care (drive 0).
- stall=1, flush=0:
  - Identity, immediate and control outputs hold.
  - id_rs1_data/id_rs2_data reload from the register file using the held id_rs1/id_rs2, so writebacks during a stall are picked up.
- Normal load: id_valid<=if_valid. When if_valid=0, all control outputs are 0.
- Register file:
  - Write at posedge when wb_we=1 and wb_rd!=0.
  - Writes to x0 are ignored; reads of x0 return 0.
  - Writeback occurs regardless of stall and flush.
- Immediates (sign bit is instr[31]):
  - I-type: instr[31:20]
  - S-type: {instr[31:25], instr[11:7]}
  - B-type: {instr[31], instr[7], instr[30:25], instr[11:8], 0}
  - U-type: {instr[31:12], 12'b0}
  - J-type: {instr[31], instr[19:12], instr[20], instr[30:21], 0}
  - R-type: id_imm=0.
- Opcodes decoded: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP.
- ALU op: from funct3/funct7[5]. SUB only for OP; SRA for OP and OP-IMM. LUI uses PASS_B.
- id_rd is 0 for STORE and BRANCH. id_reg_write=0 when rd=0.
- Illegal (unknown opcode, or a bad funct7 for OP or shifts):
  - id_illegal=1, id_valid follows if_valid.
  - reg_write, mem_read, mem_write, branch and jump are all 0.
- FENCE/SYSTEM are treated as illegal in this revision.

Optional Feature:
- DECODE_BYPASS_EN defined: write-through forwarding. A read whose index equals wb_rd (nonzero, wb_we=1) in the same cycle returns wb_data.
- Undefined: the read returns the pre-write value. The hazard unit must insert one extra stall cycle for WB→ID dependencies.

Decomposition:
- Package riscv_pkg holds:
  - the opcode constants;
  - alu_op_t, a 4-bit enum: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, PASS_B;
  - an imm_fmt_t enum (I, S, B, U, J, R).
- Sub-module register_file:
  - Two asynchronous read ports, one synchronous write port.
  - Contains the x0 rule and the DECODE_BYPASS_EN bypass.

Test Plan:
- Reset, then if_valid=1 with 0x00500093 (addi x1,x0,5) → next cycle: id_valid=1, id_rd=1, id_imm=5, alu_op=ADD, alu_src_imm=1, reg_write=1.
- Write x1=0x10 via wb, then 0x0020A423 (sw x2,8(x1)) → id_rs1_data=0x10, id_imm=8, mem_write=1, reg_write=0, id_rd=0.
- 0xFE000CE3 (beq x0,x0,-8) → id_imm=0xFFFFFFF8, branch=1. 0x123452B7 (lui x5) → id_imm=0x12345000, alu_op=PASS_B.
- stall=1 for 3 cycles while writing x1=0x99 → control outputs frozen; id_rs1_data becomes 0x99. flush and stall together → id_valid=0.
- 0x00000000 → id_illegal=1, all side-effect controls 0. Write to x0 → x0 still reads 0.
- Same-cycle wb x1 and decode reading x1 → new value when DECODE_BYPASS_EN is defined, old value otherwise.
